// File: rtl/ind_pkg.sv
// Shared types and constants for the indicator sequencer.
// Consumed by ind_seq_ctrl and ind_prescaler.
package ind_pkg;

  localparam int IND_W   = 3;
  localparam int PAT_LEN = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Fixed indicator pattern, indexed by the step index.
  localparam logic [IND_W-1:0] PAT [PAT_LEN] = '{
    3'd0, 3'd4, 3'd1, 3'd3, 3'd6, 3'd2, 3'd7, 3'd5
  };

  function automatic logic [IND_W-1:0] first_idx(input logic down);
    return down ? {IND_W{1'b1}} : {IND_W{1'b0}};
  endfunction

  function automatic logic [IND_W-1:0] last_idx(input logic down);
    return down ? {IND_W{1'b0}} : {IND_W{1'b1}};
  endfunction

  // Natural 3-bit wrap in both directions.
  function automatic logic [IND_W-1:0] next_idx(input logic [IND_W-1:0] idx,
                                                input logic down);
    return down ? idx - 1'b1 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/ind_prescaler.sv
// Step-rate prescaler: counts 0..load_val while enabled and emits a one-cycle
// tick on the terminal count; clear forces the count back to zero.
module ind_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [DIV_W-1:0] load_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && !clear && (cnt == load_val);

  // load_val only changes together with clear, so cnt never passes it.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ind_seq_ctrl.sv
// Rate-controlled sequencer for the 3-bit indicator pattern.
// Optional down-counting via the IND_SEQ_DIR_EN macro (adds the dir port).
module ind_seq_ctrl
  import ind_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [DIV_W-1:0] div,
`ifdef IND_SEQ_DIR_EN
  input  logic             dir,
`endif
  output logic             busy,
  output logic             done,
  output logic [IND_W-1:0] step_idx,
  output logic [IND_W-1:0] ind_out
);

  state_e           state;
  logic [DIV_W-1:0] div_l;
  logic             mode_l;
  logic             dir_l;
  logic             dir_in;
  logic             tick;
  logic             pre_clear;
  logic             run;

`ifdef IND_SEQ_DIR_EN
  assign dir_in = dir;
`else
  assign dir_in = 1'b0;
`endif

  assign run       = (state == ST_RUN);
  // Any command, or leaving RUN, parks the prescaler at zero.
  assign pre_clear = start || stop || !run;

  ind_prescaler #(.DIV_W(DIV_W)) u_pre (
    .clk      (clk),
    .rst      (rst),
    .clear    (pre_clear),
    .en       (run),
    .load_val (div_l),
    .tick     (tick)
  );

  // Priority: rst > stop > start > tick. stop outside RUN just lands in IDLE,
  // which is where IDLE/DONE go anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      step_idx <= '0;
      div_l    <= '0;
      mode_l   <= 1'b0;
      dir_l    <= 1'b0;
    end else if (stop) begin
      state <= ST_IDLE;
    end else if (start) begin
      state    <= ST_RUN;
      step_idx <= first_idx(dir_in);
      div_l    <= div;
      mode_l   <= mode;
      dir_l    <= dir_in;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (tick) begin
            if (mode_l && (step_idx == last_idx(dir_l))) begin
              state <= ST_DONE;
            end else begin
              step_idx <= next_idx(step_idx, dir_l);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = run;
  assign done    = (state == ST_DONE);
  assign ind_out = PAT[step_idx];

endmodule

// File: tb/tb_ind_seq_ctrl.sv
// Self-checking bench for ind_seq_ctrl: time-since-start reference model plus
// directed sequences with literal expectations. Define IND_SEQ_DIR_EN for dir.
module tb_ind_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] div;
  logic       dir_drv;
  logic       busy;
  logic       done;
  logic [2:0] step_idx;
  logic [2:0] ind_out;

  int checks   = 0;
  int failures = 0;

  ind_seq_ctrl #(.DIV_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .div      (div),
`ifdef IND_SEQ_DIR_EN
    .dir      (dir_drv),
`endif
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx),
    .ind_out  (ind_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int patm [8] = '{0, 4, 1, 3, 6, 2, 7, 5};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a running sequence is described by cycles elapsed since start (m_k);
  // the index is simply k/(div+1), wrapped or clamped by mode, mirrored by dir.
  bit m_valid = 0;
  bit m_phase = 0;
  bit m_mode  = 0;
  bit m_dir   = 0;
  int m_k     = 0;
  int m_div   = 0;
  int m_hold  = 0;

  function automatic int m_len();
    return 8 * (m_div + 1);
  endfunction

  function automatic int m_idx();
    int q;
    int v;
    q = m_k / (m_div + 1);
    if (m_mode) v = (q > 7) ? 7 : q;
    else        v = q % 8;
    return m_dir ? 7 - v : v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1;
      m_phase = 0;
      m_hold  = 0;
    end else if (stop) begin
      if (m_phase) m_hold = m_idx();
      m_phase = 0;
    end else if (start) begin
      m_phase = 1;
      m_k     = 0;
      m_div   = int'(div);
      m_mode  = mode;
      m_dir   = dir_drv;
    end else if (m_phase) begin
      if (m_mode && m_k == m_len()) begin
        m_hold  = m_idx();
        m_phase = 0;
      end else begin
        m_k++;
      end
    end
  end

  always @(negedge clk) begin
    int  e_idx;
    bit  e_busy;
    bit  e_done;
    if (m_valid) begin
      e_done = m_phase && m_mode && (m_k == m_len());
      e_busy = m_phase && !e_done;
      e_idx  = m_phase ? m_idx() : m_hold;
      chk("model_step_idx", int'(step_idx), e_idx);
      chk("model_ind_out",  int'(ind_out),  patm[e_idx]);
      chk("model_busy",     int'(busy),     int'(e_busy));
      chk("model_done",     int'(done),     int'(e_done));
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int lit_up [9] = '{0, 4, 1, 3, 6, 2, 7, 5, 0};
  int lit_dn [8] = '{5, 7, 2, 6, 3, 1, 4, 0};

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; div = 8'd0; dir_drv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      chk("idle_ind", int'(ind_out), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
      @(negedge clk);
    end

    // Continuous, div=2; input changes after start must be ignored
    mode = 1'b0; div = 8'd2;
    pulse_start();
    div = 8'd9; mode = 1'b1;
    for (int i = 0; i < 27; i++) begin
      chk("cont_ind", int'(ind_out), lit_up[i/3]);
      chk("cont_busy", int'(busy), 1);
      chk("cont_done", int'(done), 0);
      @(negedge clk);
    end
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    chk("cont_stop_busy", int'(busy), 0);

    // Single pass, div=0
    mode = 1'b1; div = 8'd0;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      chk("single_ind", int'(ind_out), lit_up[i]);
      chk("single_busy", int'(busy), 1);
      @(negedge clk);
    end
    chk("single_done", int'(done), 1);
    chk("single_done_busy", int'(busy), 0);
    chk("single_done_ind", int'(ind_out), 5);
    @(negedge clk);
    chk("single_after_done", int'(done), 0);
    chk("single_after_idx", int'(step_idx), 7);
    repeat (3) @(negedge clk);
    chk("single_hold_ind", int'(ind_out), 5);

    // Stop at the 6th RUN cycle, div=3
    mode = 1'b0; div = 8'd3;
    pulse_start();
    repeat (5) @(negedge clk);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    chk("stop_idx", int'(step_idx), 1);
    chk("stop_busy", int'(busy), 0);
    chk("stop_done", int'(done), 0);
    repeat (4) @(negedge clk);
    chk("stop_frozen_idx", int'(step_idx), 1);
    chk("stop_frozen_ind", int'(ind_out), 4);

    // start+stop together in RUN acts as stop
    mode = 1'b0; div = 8'd1;
    pulse_start();
    repeat (3) @(negedge clk);
    start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
    chk("startstop_busy", int'(busy), 0);
    chk("startstop_idx", int'(step_idx), 1);

    // Restart mid-run with div 1 -> 4
    div = 8'd1;
    pulse_start();
    repeat (3) @(negedge clk);
    div = 8'd4;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      chk("restart_dwell_idx", int'(step_idx), 0);
      chk("restart_busy", int'(busy), 1);
      @(negedge clk);
    end
    chk("restart_adv_idx", int'(step_idx), 1);

    // Reset mid-run: no done, reset values
    mode = 1'b1; div = 8'd2;
    pulse_start();
    repeat (4) @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_idx", int'(step_idx), 0);
    repeat (30) @(negedge clk);
    chk("rst_no_done", int'(done), 0);

`ifdef IND_SEQ_DIR_EN
    // Down single pass, div=1
    mode = 1'b1; div = 8'd1; dir_drv = 1'b1;
    pulse_start();
    dir_drv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("down_ind", int'(ind_out), lit_dn[i/2]);
      @(negedge clk);
    end
    chk("down_done", int'(done), 1);
    @(negedge clk);
    chk("down_final_idx", int'(step_idx), 0);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ind_seq_ctrl.md
# ind_seq_ctrl

Sequencing controller for the 3-bit indicator pattern generator. It steps the fixed 8-entry indicator pattern at a programmable rate, and supports start/stop commands, continuous or single-pass modes, and a completion pulse. It sits between the control/register logic and the indicator outputs. It replaces free-running per-clock stepping with rate-controlled, commandable sequencing.

## Interface
Parameters:
- DIV_W, 8, width of the step-period divider.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high; clock clk.
- start  in  1  single-cycle command; begins or restarts a sequence.
- stop  in  1  single-cycle command; aborts a running sequence.
- mode  in  1  0 = continuous (wraps forever), 1 = single pass; latched on start.
- div  in  DIV_W  step period minus one, so each pattern entry is held div+1 cycles; latched on start.
- dir  in  1  only present with IND_SEQ_DIR_EN: 0 = up, 1 = down; latched on start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a single pass completes.
- step_idx  out  3  current pattern index.
- ind_out  out  3  PAT[step_idx].

## Operation
- Pattern table PAT[0..7] = 0,4,1,3,6,2,7,5.
- States:
  - IDLE: outputs hold; start → RUN.
  - RUN: prescaler counts 0..div_l; a step tick occurs when count == div_l, then count returns to 0.
  - DONE: lasts one cycle, then → IDLE.
- On start, from any state:
  - state ← RUN, count ← 0, step_idx ← 0 (or 7 when dir=1).
  - div, mode and dir are latched into div_l, mode_l and dir_l.
- Tick in continuous mode: step_idx increments mod 8 (7→0).
- Tick in single-pass mode:
  - If step_idx == 7, step_idx holds and state → DONE.
  - Otherwise step_idx increments.
- stop in RUN: → IDLE, step_idx and ind_out freeze, done is not pulsed.
- stop in IDLE or DONE: ignored.
- Priority: rst > stop > start > tick. start and stop in the same cycle act as stop.
- start during RUN restarts cleanly: count and index are cleared, and new div/mode values are latched.
- Changes to div, mode or dir outside a start cycle have no effect until the next start.
- div = 0: the index advances every RUN cycle.
- Arithmetic: the prescaler is DIV_W bits, unsigned, compared with == only, with no overflow path. The index is 3 bits with natural wrap.

## Timing
- Reset values: state IDLE, count 0, step_idx 0, ind_out 0, busy 0, done 0, latched fields 0.
- All state, count and step_idx are registers. ind_out is a combinational decode of the step_idx register, so it changes on the same edge as step_idx.
- start sampled at edge N: after edge N, busy = 1 and step_idx = 0.
- First advance occurs at edge N + div + 1.
- Each pattern entry is visible for exactly div+1 cycles.
- Single pass:
  - The RUN dwell is 8·(div+1) cycles.
  - done is high for the cycle after the final tick, with busy = 0 in that cycle.
  - IDLE follows, with step_idx = 7.
- stop sampled at edge M: busy = 0 after edge M.
- rst asserted mid-run: all reset values apply after the edge; no done pulse.

## Configuration
- IND_SEQ_DIR_EN defined:
  - The dir port exists.
  - dir_l = 1 decrements the index mod 8 (0→7); single pass starts at 7 and ends on the tick at index 0, holding 0.
- IND_SEQ_DIR_EN undefined: no dir port; behaviour is up-only as described above.

## Structure
- Shared package ind_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the PAT constant array;
  - the IND_W = 3 constant.
- One natural sub-module, ind_prescaler. It takes clear, enable and a DIV_W load value, and outputs the one-cycle tick.
- FSM, index register and decode stay in ind_seq_ctrl.

## Test plan
- rst, then idle for 10 cycles → ind_out = 0, busy = 0, done = 0 throughout.
- mode=0, div=2, pulse start → ind_out is 0,4,1,3,6,2,7,5,0 with each value held 3 cycles; busy stays 1 and done is never asserted.
- mode=1, div=0, pulse start → 8 RUN cycles showing 0,4,1,3,6,2,7,5; done high for 1 cycle; then IDLE with ind_out = 5.
- mode=0, div=3, stop at the 6th RUN cycle → step_idx = 1 frozen; busy = 0 the next cycle; no done.
- start and stop in the same cycle while in RUN → IDLE. start mid-run with div changed from 1 to 4 → step_idx = 0, then a 5-cycle dwell.
- With IND_SEQ_DIR_EN: mode=1, dir=1, div=1 → ind_out is 5,7,2,6,3,1,4,0 at 2 cycles each; done pulses; final step_idx = 0.
